// File: rtl/param_processor_core.sv
// Parametrised multi-cycle register machine: fetches from an external combinational ROM,
// executes ALU / MOVI / BRANCH / HALT classes with persistent C/Z/OV flags and a writeback strobe.
module param_processor_core #(
  parameter  int DATA_W   = 8,
  parameter  int NUM_REGS = 16,
  parameter  int PC_W     = 8,
  localparam int RA_W     = $clog2(NUM_REGS),
  localparam int OPND_W   = (DATA_W > PC_W) ? ((DATA_W > RA_W) ? DATA_W : RA_W)
                                            : ((PC_W > RA_W) ? PC_W : RA_W),
  localparam int IW       = 5 + RA_W + OPND_W
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [PC_W-1:0]   instr_addr,
  input  logic [IW-1:0]     instr_data,
  output logic [DATA_W-1:0] result_out,
  output logic              wb_valid,
  output logic [RA_W-1:0]   wb_addr,
  output logic              flag_c,
  output logic              flag_z,
  output logic              flag_ov,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [1:0] CL_ALU  = 2'b00;
  localparam logic [1:0] CL_MOVI = 2'b01;
  localparam logic [1:0] CL_BR   = 2'b10;

  state_t              state_q, state_d;
  logic [IW-1:0]       ir_q;
  logic [PC_W-1:0]     pc_q;
  logic [DATA_W-1:0]   res_q;
  logic [DATA_W-1:0]   result_q;
  logic [RA_W-1:0]     wb_addr_q;
  logic                wb_valid_q;
  logic                flag_c_q, flag_z_q, flag_ov_q;
  logic                halted_q;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];

  logic [1:0]          cls_s;
  logic [2:0]          op_s;
  logic [RA_W-1:0]     rd_s;
  logic [RA_W-1:0]     rs_s;
  logic [OPND_W-1:0]   opnd_s;
  logic [PC_W-1:0]     pc_inc_s;
  logic                taken_s;
  logic [DATA_W-1:0]   a_s, b_s;
  logic [DATA_W:0]     sum_s, diff_s;
  logic [DATA_W-1:0]   alu_res_s;
  logic                alu_c_s, alu_ov_s;

  assign cls_s    = ir_q[IW-1 -: 2];
  assign op_s     = ir_q[IW-3 -: 3];
  assign rd_s     = ir_q[OPND_W +: RA_W];
  assign opnd_s   = ir_q[OPND_W-1:0];
  assign rs_s     = opnd_s[RA_W-1:0];
  assign pc_inc_s = pc_q + PC_W'(1);

  assign instr_addr = pc_q;
  assign result_out = result_q;
  assign wb_valid   = wb_valid_q;
  assign wb_addr    = wb_addr_q;
  assign flag_c     = flag_c_q;
  assign flag_z     = flag_z_q;
  assign flag_ov    = flag_ov_q;
  assign halted     = halted_q;

  // Branch condition evaluated against the flags as they stand at DECODE.
  always_comb begin
    taken_s = 1'b0;
    case (op_s)
      3'b000:  taken_s = 1'b1;
      3'b001:  taken_s = flag_z_q;
      3'b010:  taken_s = flag_c_q;
      default: taken_s = 1'b0;
    endcase
  end

  // ALU: both operands read the pre-write register values, so rd==rs is safe.
  always_comb begin
    a_s       = regs_q[rd_s];
    b_s       = regs_q[rs_s];
    sum_s     = {1'b0, a_s} + {1'b0, b_s};
    diff_s    = {1'b0, a_s} - {1'b0, b_s};
    alu_res_s = '0;
    alu_c_s   = 1'b0;
    alu_ov_s  = 1'b0;
    case (op_s)
      3'b000: begin
        alu_res_s = sum_s[DATA_W-1:0];
        alu_c_s   = sum_s[DATA_W];
        alu_ov_s  = (a_s[DATA_W-1] == b_s[DATA_W-1]) && (sum_s[DATA_W-1] != a_s[DATA_W-1]);
      end
      3'b001: begin
        alu_res_s = diff_s[DATA_W-1:0];
        alu_c_s   = diff_s[DATA_W];
        alu_ov_s  = (a_s[DATA_W-1] != b_s[DATA_W-1]) && (diff_s[DATA_W-1] != a_s[DATA_W-1]);
      end
      3'b010:  alu_res_s = a_s & b_s;
      3'b011:  alu_res_s = a_s | b_s;
      3'b100:  alu_res_s = a_s ^ b_s;
      3'b101:  alu_res_s = ~a_s;
      3'b110: begin
        alu_res_s = {a_s[DATA_W-2:0], 1'b0};
        alu_c_s   = a_s[DATA_W-1];
      end
      3'b111: begin
        alu_res_s = {1'b0, a_s[DATA_W-1:1]};
        alu_c_s   = a_s[0];
      end
      default: alu_res_s = '0;
    endcase
  end

  // Next-state logic for the fetch/decode/execute/writeback sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (cls_s)
          CL_ALU:  state_d = S_EXEC;
          CL_MOVI: state_d = S_WB;
          CL_BR:   state_d = S_FETCH;
          default: state_d = S_HALT;
        endcase
      end
      S_EXEC:   state_d = S_WB;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Datapath, register file and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q       <= '0;
      pc_q       <= '0;
      res_q      <= '0;
      result_q   <= '0;
      wb_addr_q  <= '0;
      wb_valid_q <= 1'b0;
      flag_c_q   <= 1'b0;
      flag_z_q   <= 1'b0;
      flag_ov_q  <= 1'b0;
      halted_q   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      wb_valid_q <= 1'b0;
      case (state_q)
        S_FETCH: ir_q <= instr_data;
        S_DECODE: begin
          case (cls_s)
            CL_ALU:  ;
            CL_MOVI: res_q <= opnd_s[DATA_W-1:0];
            CL_BR:   pc_q <= taken_s ? opnd_s[PC_W-1:0] : pc_inc_s;
            default: halted_q <= 1'b1;
          endcase
        end
        S_EXEC: begin
          res_q     <= alu_res_s;
          flag_c_q  <= alu_c_s;
          flag_z_q  <= (alu_res_s == '0);
          flag_ov_q <= alu_ov_s;
        end
        S_WB: begin
          regs_q[rd_s] <= res_q;
          result_q     <= res_q;
          wb_addr_q    <= rd_s;
          wb_valid_q   <= 1'b1;
          pc_q         <= pc_inc_s;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_param_processor_core.sv
// Scoreboard bench for param_processor_core: directed programs in a behavioural ROM,
// expected writebacks queued per program and checked by an independent monitor.
module tb_param_processor_core;

  logic        clk;
  logic        rst_n;
  logic [7:0]  instr_addr;
  logic [16:0] instr_data;
  logic [7:0]  result_out;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic        flag_c, flag_z, flag_ov;
  logic        halted;

  logic [16:0] rom [256];
  assign instr_data = rom[instr_addr];

  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
    logic       c;
    logic       z;
    logic       ov;
  } wb_t;

  wb_t sb [$];
  int  checks   = 0;
  int  failures = 0;

  param_processor_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_addr (instr_addr),
    .instr_data (instr_data),
    .result_out (result_out),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .flag_c     (flag_c),
    .flag_z     (flag_z),
    .flag_ov    (flag_ov),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] f_movi(input logic [3:0] rd, input logic [7:0] imm);
    return {2'b01, 3'b000, rd, imm};
  endfunction
  function automatic logic [16:0] f_alu(input logic [2:0] op, input logic [3:0] rd, input logic [3:0] rs);
    return {2'b00, op, rd, 4'b0000, rs};
  endfunction
  function automatic logic [16:0] f_br(input logic [2:0] op, input logic [7:0] tgt);
    return {2'b10, op, 4'b0000, tgt};
  endfunction
  function automatic logic [16:0] f_halt();
    return {2'b11, 15'd0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_wb(input logic [3:0] a, input logic [7:0] d, input logic c, input logic z, input logic ov);
    wb_t e;
    e.a = a; e.d = d; e.c = c; e.z = z; e.ov = ov;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_reset();
    rst_n = 1'b0;
    sb.delete();
    for (int i = 0; i < 256; i++) rom[i] = f_halt();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int max);
    bit done = 1'b0;
    for (int i = 0; i < max && !done; i++) begin
      if (sb.size() == 0) done = 1'b1;
      else tick();
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s timeout pending=%0d expected=0", name, sb.size());
    end
  endtask

  task automatic wait_addr(input string name, input logic [7:0] addr, input int max);
    bit done = 1'b0;
    for (int i = 0; i < max && !done; i++) begin
      if (instr_addr == addr) done = 1'b1;
      else tick();
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s timeout instr_addr=0x%0h expected=0x%0h", name, instr_addr, addr);
    end
  endtask

  // Monitor: every writeback strobe must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && wb_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL wb_unexpected actual addr=%0d data=0x%0h expected none", wb_addr, result_out);
      end else begin
        wb_t e;
        e = sb.pop_front();
        if ({wb_addr, result_out, flag_c, flag_z, flag_ov} !== e) begin
          failures++;
          $display("FAIL wb_compare actual a=%0d d=0x%0h czo=%b%b%b expected a=%0d d=0x%0h czo=%b%b%b",
                   wb_addr, result_out, flag_c, flag_z, flag_ov, e.a, e.d, e.c, e.z, e.ov);
        end
      end
    end
  end

  initial begin
    // ---------------- Program 1: MOVI timing, ALU ops and flags ----------------
    start_reset();
    rom[0]  = f_movi(4'd1, 8'h05);         exp_wb(4'd1, 8'h05, 1'b0, 1'b0, 1'b0);
    rom[1]  = f_movi(4'd1, 8'hFF);         exp_wb(4'd1, 8'hFF, 1'b0, 1'b0, 1'b0);
    rom[2]  = f_movi(4'd2, 8'h01);         exp_wb(4'd2, 8'h01, 1'b0, 1'b0, 1'b0);
    rom[3]  = f_alu(3'b000, 4'd1, 4'd2);   exp_wb(4'd1, 8'h00, 1'b1, 1'b1, 1'b0);
    rom[4]  = f_movi(4'd3, 8'h80);         exp_wb(4'd3, 8'h80, 1'b1, 1'b1, 1'b0);
    rom[5]  = f_movi(4'd4, 8'h01);         exp_wb(4'd4, 8'h01, 1'b1, 1'b1, 1'b0);
    rom[6]  = f_alu(3'b001, 4'd3, 4'd4);   exp_wb(4'd3, 8'h7F, 1'b0, 1'b0, 1'b1);
    rom[7]  = f_alu(3'b010, 4'd3, 4'd3);   exp_wb(4'd3, 8'h7F, 1'b0, 1'b0, 1'b0);
    rom[8]  = f_alu(3'b100, 4'd3, 4'd3);   exp_wb(4'd3, 8'h00, 1'b0, 1'b1, 1'b0);
    rom[9]  = f_movi(4'd5, 8'hA5);         exp_wb(4'd5, 8'hA5, 1'b0, 1'b1, 1'b0);
    rom[10] = f_alu(3'b101, 4'd5, 4'd0);   exp_wb(4'd5, 8'h5A, 1'b0, 1'b0, 1'b0);
    rom[11] = f_alu(3'b110, 4'd5, 4'd0);   exp_wb(4'd5, 8'hB4, 1'b0, 1'b0, 1'b0);
    rom[12] = f_alu(3'b110, 4'd5, 4'd0);   exp_wb(4'd5, 8'h68, 1'b1, 1'b0, 1'b0);
    rom[13] = f_alu(3'b111, 4'd5, 4'd0);   exp_wb(4'd5, 8'h34, 1'b0, 1'b0, 1'b0);
    rom[14] = f_alu(3'b011, 4'd5, 4'd2);   exp_wb(4'd5, 8'h35, 1'b0, 1'b0, 1'b0);
    rom[15] = f_alu(3'b001, 4'd2, 4'd5);   exp_wb(4'd2, 8'hCC, 1'b1, 1'b0, 1'b0);
    rom[16] = f_halt();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_instr_addr", {24'd0, instr_addr}, 32'd0);
    chk("rst_result_out", {24'd0, result_out}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_flags", {29'd0, flag_c, flag_z, flag_ov}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    release_reset();
    tick(); tick();
    chk("movi_wb_not_yet", {31'd0, wb_valid}, 32'd0);
    tick();
    chk("movi_wb_3rd_edge", {31'd0, wb_valid}, 32'd1);
    wait_drain("p1_drain", 120);
    repeat (4) tick();
    chk("p1_halted", {31'd0, halted}, 32'd1);
    chk("p1_halt_pc", {24'd0, instr_addr}, 32'd16);

    // ---------------- Program 2: countdown loop with BRZ/JMP, HALT at 5 ----------------
    start_reset();
    rom[0] = f_movi(4'd1, 8'h03);          exp_wb(4'd1, 8'h03, 1'b0, 1'b0, 1'b0);
    rom[1] = f_movi(4'd2, 8'h01);          exp_wb(4'd2, 8'h01, 1'b0, 1'b0, 1'b0);
    rom[2] = f_alu(3'b001, 4'd1, 4'd2);    exp_wb(4'd1, 8'h02, 1'b0, 1'b0, 1'b0);
                                           exp_wb(4'd1, 8'h01, 1'b0, 1'b0, 1'b0);
                                           exp_wb(4'd1, 8'h00, 1'b0, 1'b1, 1'b0);
    rom[3] = f_br(3'b001, 8'd5);
    rom[4] = f_br(3'b000, 8'd2);
    rom[5] = f_halt();
    repeat (2) @(posedge clk);
    release_reset();
    wait_addr("p2_reach_done", 8'd5, 80);
    chk("p2_halted_fetch", {31'd0, halted}, 32'd0);
    tick();
    chk("p2_halted_decode", {31'd0, halted}, 32'd0);
    tick();
    chk("p2_halted_set", {31'd0, halted}, 32'd1);
    repeat (50) tick();
    chk("p2_halt_pc_frozen", {24'd0, instr_addr}, 32'd5);
    chk("p2_halt_sticky", {31'd0, halted}, 32'd1);
    chk("p2_sb_empty", sb.size(), 32'd0);

    // ---------------- Program 3: BRC taken to 0xFE, NOP branch wraps 0xFF -> 0 ----------------
    start_reset();
    rom[0]    = f_movi(4'd1, 8'hFF);       exp_wb(4'd1, 8'hFF, 1'b0, 1'b0, 1'b0);
    rom[1]    = f_movi(4'd2, 8'h01);       exp_wb(4'd2, 8'h01, 1'b0, 1'b0, 1'b0);
    rom[2]    = f_alu(3'b000, 4'd1, 4'd2); exp_wb(4'd1, 8'h00, 1'b1, 1'b1, 1'b0);
    rom[3]    = f_br(3'b010, 8'hFE);
    rom[8'hFE] = f_movi(4'd6, 8'h3C);      exp_wb(4'd6, 8'h3C, 1'b1, 1'b1, 1'b0);
    rom[8'hFF] = f_br(3'b111, 8'h40);
    repeat (2) @(posedge clk);
    release_reset();
    wait_addr("p3_reach_ff", 8'hFF, 60);
    wait_addr("p3_wrap_to_0", 8'h00, 10);
    chk("p3_wrap_addr", {24'd0, instr_addr}, 32'd0);
    chk("p3_sb_empty", sb.size(), 32'd0);

    // ---------------- Program 4: asynchronous reset in the middle of ADD's EXEC ----------------
    start_reset();
    rom[0] = f_movi(4'd1, 8'h05);          exp_wb(4'd1, 8'h05, 1'b0, 1'b0, 1'b0);
    rom[1] = f_movi(4'd2, 8'h01);          exp_wb(4'd2, 8'h01, 1'b0, 1'b0, 1'b0);
    rom[2] = f_alu(3'b000, 4'd1, 4'd2);
    rom[3] = f_halt();
    repeat (2) @(posedge clk);
    release_reset();
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        tick();
        if (wb_valid === 1'b1 && wb_addr == 4'd2) seen = 1'b1;
      end
      chk("p4_second_movi_seen", {31'd0, seen}, 32'd1);
    end
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("p4_async_instr_addr", {24'd0, instr_addr}, 32'd0);
    chk("p4_async_result_out", {24'd0, result_out}, 32'd0);
    chk("p4_async_wb_addr", {28'd0, wb_addr}, 32'd0);
    chk("p4_async_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("p4_async_flags", {29'd0, flag_c, flag_z, flag_ov}, 32'd0);
    tick();
    tick();
    chk("p4_no_wb_in_reset", {31'd0, wb_valid}, 32'd0);
    chk("p4_sb_empty_before_restart", sb.size(), 32'd0);
    exp_wb(4'd1, 8'h05, 1'b0, 1'b0, 1'b0);
    exp_wb(4'd2, 8'h01, 1'b0, 1'b0, 1'b0);
    exp_wb(4'd1, 8'h06, 1'b0, 1'b0, 1'b0);
    release_reset();
    wait_drain("p4_restart_drain", 40);
    repeat (4) tick();
    chk("p4_halted", {31'd0, halted}, 32'd1);
    chk("p4_halt_pc", {24'd0, instr_addr}, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
